// File: rtl/mux2_4_arbiter_pkg.sv
// Shared encodings for the two-source round-robin arbiter: FSM states and
// the select-line values that name each source.
package mux2_4_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage : mux2_4_arbiter_pkg

// File: rtl/mux2_4_arbiter_mux2_4.sv
// Plain 2:1 word multiplexer: sel=0 passes data_a, sel=1 passes data_b.
module mux2_4 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic             sel,
   output logic [WIDTH-1:0] data_out
);

   assign data_out = sel ? data_b : data_a;

endmodule : mux2_4

// File: rtl/mux2_4_arbiter.sv
// Round-robin owner of a shared 2:1 select path; the chosen word lands in a
// one-entry output register drained through a valid/ready handshake.
module mux2_4_arbiter
   import mux2_4_arbiter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [4:0] HOLD_LIM = 5'(HOLD_MAX);

   arb_state_t       state;
   logic [3:0]       count;
   logic             last_owner;
   logic [WIDTH-1:0] mux_out;

   logic             space;
   logic             own_req;
   logic             other_req;
   logic [4:0]       count_inc;
   logic             burst_done;

   mux2_4 #(.WIDTH(WIDTH)) u_mux (
      .data_a   (data_a),
      .data_b   (data_b),
      .sel      (sel),
      .data_out (mux_out)
   );

   // Grants depend on the current owner and buffer space; sel always equals
   // the owner inside OWN_*, so the mux already presents the granted word.
   always_comb begin
      space      = !out_valid || out_ready;
      own_req    = (state == OWN_B) ? req_b : req_a;
      other_req  = (state == OWN_B) ? req_a : req_b;
      count_inc  = {1'b0, count} + 5'd1;
      burst_done = (count_inc >= HOLD_LIM);
      gnt_a      = rst_n && (state == OWN_A) && req_a && space;
      gnt_b      = rst_n && (state == OWN_B) && req_b && space;
   end

   // Once saturated the count stays at HOLD_MAX, so a late competing request
   // still forces a handoff on the owner's next accepted word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= SEL_A;
         out_valid  <= 1'b0;
         out_data   <= '0;
         count      <= 4'd0;
         last_owner <= SEL_B;
      end else begin
         if (gnt_a || gnt_b) begin
            out_data  <= mux_out;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               count <= 4'd0;
               if (req_a && req_b) begin
                  if (last_owner == SEL_B) begin
                     state <= OWN_A;
                     sel   <= SEL_A;
                  end else begin
                     state <= OWN_B;
                     sel   <= SEL_B;
                  end
               end else if (req_a) begin
                  state <= OWN_A;
                  sel   <= SEL_A;
               end else if (req_b) begin
                  state <= OWN_B;
                  sel   <= SEL_B;
               end
            end
            OWN_A, OWN_B: begin
               if (space) begin
                  if (!own_req || (burst_done && other_req)) begin
                     last_owner <= sel;
                     count      <= 4'd0;
                     if (other_req) begin
                        state <= (state == OWN_A) ? OWN_B : OWN_A;
                        sel   <= ~sel;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     count <= burst_done ? HOLD_LIM[3:0] : count_inc[3:0];
                  end
               end
            end
            default: begin
               state <= IDLE;
               sel   <= SEL_A;
               count <= 4'd0;
            end
         endcase
      end
   end

endmodule : mux2_4_arbiter

// File: tb/tb_mux2_4_arbiter.sv
// Directed bench for mux2_4_arbiter: a vector table for reset, single-source
// and fairness behaviour, then hand sequences for stalls, handoff and reset.
module tb_mux2_4_arbiter;

   typedef struct packed {
      logic       rst_n;
      logic       req_a;
      logic [3:0] data_a;
      logic       req_b;
      logic [3:0] data_b;
      logic       out_ready;
      logic       exp_gnt_a;
      logic       exp_gnt_b;
      logic       exp_sel;
      logic       exp_valid;
      logic [3:0] exp_data;
   } vec_t;

   localparam int NUM_VECS = 19;

   logic       clk;
   logic       rst_n;
   logic       req_a;
   logic [3:0] data_a;
   logic       req_b;
   logic [3:0] data_b;
   logic       gnt_a;
   logic       gnt_b;
   logic       sel;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;

   int   numApplied;
   int   numMiscompares;
   vec_t vecs [NUM_VECS];

   mux2_4_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_a     (req_a),
      .data_a    (data_a),
      .req_b     (req_b),
      .data_b    (data_b),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic ra, input logic [3:0] da,
                                input logic rb, input logic [3:0] db, input logic rdy);
      rst_n     = r;
      req_a     = ra;
      data_a    = da;
      req_b     = rb;
      data_b    = db;
      out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic compareField(input string name, input string field,
                               input logic [3:0] actual, input logic [3:0] required);
      numApplied++;
      if (actual !== required) begin
         numMiscompares++;
         $display("[TB] FAIL %s %s: got %0h, expected %0h", name, field, actual, required);
      end
   endtask

   task automatic checkOutput(input string name, input logic eGa, input logic eGb,
                              input logic eSel, input logic eValid, input logic [3:0] eData);
      compareField(name, "gnt_a",     {3'b0, gnt_a},     {3'b0, eGa});
      compareField(name, "gnt_b",     {3'b0, gnt_b},     {3'b0, eGb});
      compareField(name, "sel",       {3'b0, sel},       {3'b0, eSel});
      compareField(name, "out_valid", {3'b0, out_valid}, {3'b0, eValid});
      compareField(name, "out_data",  out_data,          eData);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string name, input logic r, input logic ra, input logic [3:0] da,
                       input logic rb, input logic [3:0] db, input logic rdy,
                       input logic eGa, input logic eGb, input logic eSel,
                       input logic eValid, input logic [3:0] eData);
      applyStimulus(r, ra, da, rb, db, rdy);
      checkOutput(name, eGa, eGb, eSel, eValid, eData);
   endtask

   initial begin
      numApplied     = 0;
      numMiscompares = 0;

      // rst, ra, da, rb, db, rdy | gnt_a, gnt_b, sel, valid, data
      vecs[0]  = '{1'b0, 1'b1, 4'h1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      vecs[1]  = '{1'b0, 1'b1, 4'h1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      vecs[2]  = '{1'b1, 1'b1, 4'h1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      vecs[3]  = '{1'b1, 1'b1, 4'h1, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
      vecs[4]  = '{1'b1, 1'b1, 4'h2, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1};
      vecs[5]  = '{1'b1, 1'b1, 4'h3, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2};
      vecs[6]  = '{1'b1, 1'b1, 4'h4, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3};
      vecs[7]  = '{1'b1, 1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4};
      vecs[8]  = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5};
      vecs[9]  = '{1'b1, 1'b1, 4'h6, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
      vecs[10] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5};
      vecs[11] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA};
      vecs[12] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB};
      vecs[13] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC};
      vecs[14] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD};
      vecs[15] = '{1'b1, 1'b1, 4'h7, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6};
      vecs[16] = '{1'b1, 1'b1, 4'h8, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7};
      vecs[17] = '{1'b1, 1'b1, 4'h9, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8};
      vecs[18] = '{1'b1, 1'b1, 4'h6, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h9};

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].req_a, vecs[i].data_a,
                       vecs[i].req_b, vecs[i].data_b, vecs[i].out_ready);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt_a, vecs[i].exp_gnt_b,
                     vecs[i].exp_sel, vecs[i].exp_valid, vecs[i].exp_data);
      end

      // Stall with a full buffer, then release; the burst count must not
      // have advanced during the stall, so B still gets exactly three more.
      step("stall0", 1, 1, 4'h6, 1, 4'hF, 0, 0, 0, 1, 1, 4'hE);
      step("stall1", 1, 1, 4'h6, 1, 4'hF, 0, 0, 0, 1, 1, 4'hE);
      step("stall2", 1, 1, 4'h6, 1, 4'hF, 0, 0, 0, 1, 1, 4'hE);
      step("resume", 1, 1, 4'h6, 1, 4'hF, 1, 0, 1, 1, 1, 4'hE);
      step("b_cnt3", 1, 1, 4'h6, 1, 4'h1, 1, 0, 1, 1, 1, 4'hF);
      step("b_cnt4", 1, 1, 4'h6, 1, 4'h2, 1, 0, 1, 1, 1, 4'h1);
      step("a_back", 1, 1, 4'h6, 1, 4'h5, 1, 1, 0, 0, 1, 4'h2);

      // A releases after two words; B takes over with no idle cycle.
      step("a_word2", 1, 1, 4'h7, 1, 4'h5, 1, 1, 0, 0, 1, 4'h6);
      step("a_drop",  1, 0, 4'h7, 1, 4'h5, 1, 0, 0, 0, 1, 4'h7);
      step("b_take",  1, 0, 4'h7, 1, 4'h5, 1, 0, 1, 1, 0, 4'h7);
      step("b_word2", 1, 0, 4'h7, 1, 4'h6, 1, 0, 1, 1, 1, 4'h5);

      // Reset in the middle of a B burst; A must win the first tie after.
      step("rst_mid",  0, 1, 4'h3, 1, 4'h7, 1, 0, 0, 1, 1, 4'h6);
      step("rst_idle", 1, 1, 4'h3, 1, 4'h7, 1, 0, 0, 0, 0, 4'h0);
      step("rst_a1",   1, 1, 4'h3, 1, 4'h7, 1, 1, 0, 0, 0, 4'h0);
      step("rst_a2",   1, 1, 4'h3, 1, 4'h7, 1, 1, 0, 0, 1, 4'h3);

      $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompares);
      $finish;
   end

endmodule : tb_mux2_4_arbiter

// File: doc/mux2_4_arbiter.md
Name: mux2_4_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 WIDTH-bit select path (sel=0 -> source A, sel=1 -> source B) between two requesters.
- Drives the select and captures the chosen word into a one-entry output register with a valid/ready handshake toward a single consumer.
- Sits between two producer blocks and one consumer. It owns the select line, so no producer drives it directly.

Parameters:
- WIDTH, 4, data width of each source and of the output.
- HOLD_MAX, 4, maximum consecutive accepted words from one source while the other source is requesting (range 1..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req_a  input  1  source A has a word on data_a; held with data stable until gnt_a.
- data_a  input  WIDTH  source A word.
- req_b  input  1  source B has a word on data_b; held with data stable until gnt_b.
- data_b  input  WIDTH  source B word.
- gnt_a  output  1  combinational; high in the cycle A's word is accepted.
- gnt_b  output  1  combinational; high in the cycle B's word is accepted.
- sel  output  1  registered mux select/owner: 0 = A, 1 = B.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, sel=0, out_valid=0, out_data=0, burst count=0, last_owner=B, so A wins the first tie.
  - Reset mid-transfer discards any buffered word. gnt_a and gnt_b are forced to 0 while rst_n=0.
- Buffer space: space = !out_valid | out_ready. A pass-through transfer is allowed in the same cycle as a drain.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - No grants.
  - If req_a & req_b: go to OWN_x, where x is the source that is not last_owner.
  - If only one request is present: go to that source's OWN state.
  - sel is set on entry to OWN_*. First grant comes 1 cycle after the request is seen.
- OWN_A (symmetric for OWN_B):
  - gnt_a = req_a & space.
  - On gnt_a: out_data<=data_a, out_valid<=1, count<=count+1.
  - Leave the state when either of these holds:
    - !req_a: go to OWN_B if req_b, else IDLE.
    - gnt_a accepted with count+1 == HOLD_MAX and req_b: go to OWN_B.
  - On leaving: last_owner<=A, count<=0.
  - If req_b is absent, the count saturates at HOLD_MAX and A keeps ownership.
- Switching directly OWN_A -> OWN_B costs no idle cycle. The new owner can be granted in the cycle after the switch.
- Output drain:
  - If out_valid & out_ready with no new accept in that cycle: out_valid<=0.
  - out_data holds its last value until overwritten.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (registered, 1 cycle).
- Throughput: 1 word/cycle when out_ready is held high.
- Backpressure:
  - out_ready=0 with out_valid=1 means no grants; state and count are frozen.
  - A requester may not drop req before it is granted. If it does, the arbiter treats it as "no request" at the next evaluation.
- At most one of gnt_a/gnt_b is high in any cycle. A grant always matches sel.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2) and the SEL_A=0 / SEL_B=1 constants.
- Sub-module: the existing mux2_4 instance performs the data selection (inputs data_a, data_b, select sel), feeding the output register.
- Arbitration FSM, burst counter and output register stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, out_valid=0, out_data=0000, sel=0. Release -> OWN_A entered, first gnt_a one cycle later.
- Single source: req_a=1, data_a sequence 0001,0010,0011, out_ready=1 -> gnt_a every cycle in OWN_A, out_data follows 1 cycle later, sel=0 throughout, never switches.
- Fairness: req_a=req_b=1 continuously, out_ready=1, HOLD_MAX=4 -> 4 gnt_a then 4 gnt_b alternating, sel toggles 0->1->0, no dead cycle at switches.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with both requesting -> no grants, out_data stable, count frozen. Raise out_ready -> grant resumes in that same cycle.
- Release handoff: in OWN_A drop req_a after 2 words while req_b=1 with data_b=0101 -> next state OWN_B, sel=1, out_data=0101 one cycle after gnt_b.
- Mid-operation reset: assert rst_n=0 during an OWN_B burst -> next edge: out_valid=0, sel=0, state IDLE. After release with both requesting, A is granted first.
